// File: rtl/fib_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fib_mon_pkg
// Brief   : Shared phase/error encodings and default limits for the
//           (x, y) counter step monitor.
// Revision: 1.0 - initial release
// ============================================================================
package fib_mon_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_FLAT = 3'd1,
        PH_RAMP = 3'd2,
        PH_DONE = 3'd3,
        PH_FAIL = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_INIT = 3'd1,
        ERR_BAD_X    = 3'd2,
        ERR_BAD_Y    = 3'd3,
        ERR_INV_FAIL = 3'd4
    } err_e;

    localparam int c_X_KNEE  = 100;
    localparam int c_X_LIMIT = 200;
    localparam int c_Y_INIT  = 100;

endpackage : fib_mon_pkg
`default_nettype wire

// File: rtl/fib_step_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : fib_step_monitor_if
// Brief   : Sample stream in, verdict outputs back; master = upstream side.
// Revision: 1.0 - initial release
// ============================================================================
interface fib_step_monitor_if #(
    parameter int W     = 11,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [2:0]       phase;
    logic             done;
    logic             err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] sample_cnt;
    logic             inv_ok;

    modport master (
        output in_valid, x, y,
        input  phase, done, err, err_code, sample_cnt, inv_ok
    );

    modport slave (
        input  in_valid, x, y,
        output phase, done, err, err_code, sample_cnt, inv_ok
    );
endinterface : fib_step_monitor_if
`default_nettype wire

// File: rtl/fib_step_model.sv
`default_nettype none
// ============================================================================
// Module  : fib_step_model
// Brief   : Combinational next-pair predictor; one extra bit so x/y+1 never wraps.
// Revision: 1.0 - initial release
// ============================================================================
module fib_step_model #(
    parameter int W       = 11,
    parameter int X_KNEE  = 100,
    parameter int X_LIMIT = 200
) (
    input  wire logic [W-1:0] i_px,
    input  wire logic [W-1:0] i_py,
    output logic      [W:0]   o_exp_x,
    output logic      [W:0]   o_exp_y
);
    localparam logic [W:0] c_ONE   = (W+1)'(1);
    localparam logic [W:0] c_KNEE  = (W+1)'(X_KNEE);
    localparam logic [W:0] c_LIMIT = (W+1)'(X_LIMIT);

    logic [W:0] w_px;
    logic [W:0] w_py;
    logic [W:0] w_px1;

    assign w_px  = {1'b0, i_px};
    assign w_py  = {1'b0, i_py};
    assign w_px1 = w_px + c_ONE;

    always_comb begin
        o_exp_x = w_px;
        o_exp_y = w_py;
        if (w_px < c_LIMIT) begin
            o_exp_x = w_px1;
            if (w_px1 > c_KNEE) begin
                o_exp_y = w_py + c_ONE;
            end
        end
    end
endmodule : fib_step_model
`default_nettype wire

// File: rtl/fib_step_monitor.sv
`default_nettype none
// ============================================================================
// Module  : fib_step_monitor
// Brief   : Replays the (x, y) counter step rule on each sample, tracks the run
//           phase and latches the first error. FIB_MON_STALL_EN accepts
//           repeated pairs in FLAT/RAMP as upstream stalls.
// Revision: 1.0 - initial release
// ============================================================================
module fib_step_monitor
    import fib_mon_pkg::*;
#(
    parameter int W       = 11,
    parameter int X_KNEE  = c_X_KNEE,
    parameter int X_LIMIT = c_X_LIMIT,
    parameter int Y_INIT  = c_Y_INIT,
    parameter int CNT_W   = 16
) (
    input wire logic           clk,
    input wire logic           rst_n,
    fib_step_monitor_if.slave  bus
);
    localparam logic [W:0]       c_KNEE    = (W+1)'(X_KNEE);
    localparam logic [W:0]       c_LIMIT   = (W+1)'(X_LIMIT);
    localparam logic [W:0]       c_YINIT   = (W+1)'(Y_INIT);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    phase_e           r_phase;
    logic             r_done;
    logic             r_err;
    err_e             r_code;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inv_ok;
    logic [W-1:0]     r_px;
    logic [W-1:0]     r_py;

    logic [W:0] w_x;
    logic [W:0] w_y;
    logic [W:0] w_exp_x;
    logic [W:0] w_exp_y;
    logic       w_inv;
    logic       w_init_ok;
    logic       w_stall;
    logic       w_accept;
    err_e       w_code;
    phase_e     w_phase_nxt;

    fib_step_model #(
        .W       (W),
        .X_KNEE  (X_KNEE),
        .X_LIMIT (X_LIMIT)
    ) u_model (
        .i_px    (r_px),
        .i_py    (r_py),
        .o_exp_x (w_exp_x),
        .o_exp_y (w_exp_y)
    );

    assign w_x       = {1'b0, bus.x};
    assign w_y       = {1'b0, bus.y};
    assign w_inv     = (w_x < c_LIMIT) || (w_y == c_LIMIT);
    assign w_init_ok = (w_x == '0) && (w_y == c_YINIT);

`ifdef FIB_MON_STALL_EN
    assign w_stall = ((r_phase == PH_FLAT) || (r_phase == PH_RAMP)) &&
                     (bus.x == r_px) && (bus.y == r_py);
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_code      = ERR_NONE;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        if (bus.in_valid && (r_phase != PH_FAIL)) begin
            // IDLE has no previous pair, so only the init and invariant checks apply
            if (r_phase == PH_IDLE) begin
                if (!w_init_ok) begin
                    w_code = ERR_BAD_INIT;
                end else if (!w_inv) begin
                    w_code = ERR_INV_FAIL;
                end
            end else if (!w_inv) begin
                w_code = ERR_INV_FAIL;
            end else if (!w_stall) begin
                if (w_x != w_exp_x) begin
                    w_code = ERR_BAD_X;
                end else if (w_y != w_exp_y) begin
                    w_code = ERR_BAD_Y;
                end
            end

            if (w_code != ERR_NONE) begin
                w_phase_nxt = PH_FAIL;
            end else begin
                w_accept = 1'b1;
                case (r_phase)
                    PH_IDLE: w_phase_nxt = PH_FLAT;
                    PH_FLAT: begin
                        if (w_x == c_LIMIT) begin
                            w_phase_nxt = PH_DONE;
                        end else if (w_x > c_KNEE) begin
                            w_phase_nxt = PH_RAMP;
                        end
                    end
                    PH_RAMP: begin
                        if (w_x == c_LIMIT) begin
                            w_phase_nxt = PH_DONE;
                        end
                    end
                    default: w_phase_nxt = r_phase;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase  <= PH_IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
            r_cnt    <= '0;
            r_inv_ok <= 1'b1;
            r_px     <= '0;
            r_py     <= '0;
        end else if (bus.in_valid) begin
            r_inv_ok <= w_inv;
            r_phase  <= w_phase_nxt;
            r_done   <= (w_phase_nxt == PH_DONE);
            if (w_code != ERR_NONE) begin
                r_err  <= 1'b1;
                r_code <= w_code;
            end
            if (w_accept) begin
                r_px <= bus.x;
                r_py <= bus.y;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign bus.phase      = r_phase;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_code;
    assign bus.sample_cnt = r_cnt;
    assign bus.inv_ok     = r_inv_ok;

endmodule : fib_step_monitor
`default_nettype wire

// File: tb/tb_fib_step_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_fib_step_monitor
// Brief   : Directed table, golden/corner sequences and randomised corruption
//           runs against a behavioural model of the counter step rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fib_step_monitor;
    localparam int W     = 11;
    localparam int CNT_W = 16;
    localparam int KNEE  = 100;
    localparam int LIMIT = 200;
    localparam int YI    = 100;
    localparam int XMAX  = (1 << W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FIB_MON_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fib_step_monitor_if #(.W(W), .CNT_W(CNT_W)) bus ();

    fib_step_monitor #(
        .W       (W),
        .X_KNEE  (KNEE),
        .X_LIMIT (LIMIT),
        .Y_INIT  (YI),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: phases 0..4 = IDLE, FLAT, RAMP, DONE, FAIL
    int m_phase, m_px, m_py, m_code, m_cnt, m_inv;

    typedef struct {
        bit rn;
        bit v;
        int x;
        int y;
        int e_phase;
        int e_code;
        int e_cnt;
        int e_inv;
    } vec_t;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_px = 0; m_py = 0; m_code = 0; m_cnt = 0; m_inv = 1;
    endtask

    task automatic model_step(input int x, input int y);
        int inv, code, ex, ey;
        inv  = ((x < LIMIT) || (y == LIMIT)) ? 1 : 0;
        code = 0;
        if (m_phase == 4) begin
            m_inv = inv;
            return;
        end
        if (m_phase == 0) begin
            if (!(x == 0 && y == YI)) code = 1;
            else if (inv == 0)        code = 4;
        end else if (inv == 0) begin
            code = 4;
        end else if (!(STALL_EN && (m_phase == 1 || m_phase == 2) && x == m_px && y == m_py)) begin
            ex = (m_px < LIMIT) ? m_px + 1 : m_px;
            ey = (m_px < LIMIT && m_px + 1 > KNEE) ? m_py + 1 : m_py;
            if (x != ex)      code = 2;
            else if (y != ey) code = 3;
        end
        m_inv = inv;
        if (code != 0) begin
            m_phase = 4;
            m_code  = code;
        end else begin
            if (m_phase == 0)                       m_phase = 1;
            else if (m_phase != 3 && x == LIMIT)    m_phase = 3;
            else if (m_phase == 1 && x > KNEE)      m_phase = 2;
            m_px  = x;
            m_py  = y;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    endtask

    task automatic cycle(input bit rn, input bit v, input int x, input int y);
        rst_n        = rn;
        bus.in_valid = v;
        bus.x        = W'(x);
        bus.y        = W'(y);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        if (!rn)    model_reset();
        else if (v) model_step(x & XMAX, y & XMAX);
    endtask

    task automatic check_model(input string n);
        chk({n, ".phase"},      int'(bus.phase),      m_phase);
        chk({n, ".done"},       int'(bus.done),       (m_phase == 3) ? 1 : 0);
        chk({n, ".err"},        int'(bus.err),        (m_code != 0) ? 1 : 0);
        chk({n, ".err_code"},   int'(bus.err_code),   m_code);
        chk({n, ".sample_cnt"}, int'(bus.sample_cnt), m_cnt);
        chk({n, ".inv_ok"},     int'(bus.inv_ok),     m_inv);
    endtask

    task automatic step(input bit v, input int x, input int y, input string n);
        cycle(1'b1, v, x, y);
        check_model(n);
    endtask

    task automatic do_reset(input string n);
        cycle(1'b0, 1'b1, 0, YI);
        check_model(n);
    endtask

    function automatic int gold_y(input int gx);
        return (gx <= KNEE) ? YI : YI + gx - KNEE;
    endfunction

    task automatic golden_range(input int a, input int b);
        for (int gx = a; gx <= b; gx++) step(1'b1, gx, gold_y(gx), "golden");
    endtask

    vec_t vecs[13];

    initial begin
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        model_reset();

        vecs[0]  = '{1'b0, 1'b1,   0, 100, 0, 0, 0, 1};
        vecs[1]  = '{1'b1, 1'b1,   0, 100, 1, 0, 1, 1};
        vecs[2]  = '{1'b1, 1'b1,   1, 100, 1, 0, 2, 1};
        vecs[3]  = '{1'b1, 1'b0,   5,   5, 1, 0, 2, 1};
        vecs[4]  = '{1'b1, 1'b1,   2, 101, 4, 3, 2, 1};
        vecs[5]  = '{1'b1, 1'b1,   3, 100, 4, 3, 2, 1};
        vecs[6]  = '{1'b0, 1'b0,   0,   0, 0, 0, 0, 1};
        vecs[7]  = '{1'b1, 1'b1,   0,  99, 4, 1, 0, 1};
        vecs[8]  = '{1'b1, 1'b1,   1, 100, 4, 1, 0, 1};
        vecs[9]  = '{1'b1, 1'b1, 250,   5, 4, 1, 0, 0};
        vecs[10] = '{1'b0, 1'b1,   0, 100, 0, 0, 0, 1};
        vecs[11] = '{1'b1, 1'b1, 300,   7, 4, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b1,   0, 100, 4, 1, 0, 1};

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rn, vecs[i].v, vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d.phase", i),    int'(bus.phase),      vecs[i].e_phase);
            chk($sformatf("vec%0d.done", i),     int'(bus.done),       (vecs[i].e_phase == 3) ? 1 : 0);
            chk($sformatf("vec%0d.err", i),      int'(bus.err),        (vecs[i].e_code != 0) ? 1 : 0);
            chk($sformatf("vec%0d.err_code", i), int'(bus.err_code),   vecs[i].e_code);
            chk($sformatf("vec%0d.cnt", i),      int'(bus.sample_cnt), vecs[i].e_cnt);
            chk($sformatf("vec%0d.inv_ok", i),   int'(bus.inv_ok),     vecs[i].e_inv);
        end

        // Golden run with 5 DONE holds
        do_reset("golden_reset");
        golden_range(0, 100);
        chk("golden.flat_at_100", int'(bus.phase), 1);
        golden_range(101, 101);
        chk("golden.ramp_at_101", int'(bus.phase), 2);
        golden_range(102, 200);
        chk("golden.done_at_200", int'(bus.phase), 3);
        for (int i = 0; i < 5; i++) step(1'b1, LIMIT, LIMIT, "golden_hold");
        chk("golden.done",  int'(bus.done),       1);
        chk("golden.err",   int'(bus.err),        0);
        chk("golden.count", int'(bus.sample_cnt), 206);

        // Bad y on the ramp
        do_reset("bady_reset");
        golden_range(0, 150);
        step(1'b1, 151, 150, "bady");
        chk("bady.code",  int'(bus.err_code), 3);
        chk("bady.phase", int'(bus.phase),    4);

        // Invariant failure beats BAD_Y
        do_reset("inv_reset");
        golden_range(0, 199);
        step(1'b1, 200, 199, "inv");
        chk("inv.inv_ok", int'(bus.inv_ok),   0);
        chk("inv.code",   int'(bus.err_code), 4);

        // Repeated pair in FLAT
        do_reset("stall_reset");
        golden_range(0, 50);
        step(1'b1, 50, 100, "stall");
        if (STALL_EN) begin
            chk("stall.code", int'(bus.err_code),   0);
            chk("stall.cnt",  int'(bus.sample_cnt), 52);
            step(1'b1, 51, 100, "stall_resume");
            chk("stall.resume_code", int'(bus.err_code), 0);
        end else begin
            chk("stall.code",  int'(bus.err_code), 2);
            chk("stall.phase", int'(bus.phase),    4);
        end

        // Reset mid-run, then a clean run
        do_reset("mid_reset0");
        golden_range(0, 120);
        cycle(1'b0, 1'b1, 121, 121);
        chk("mid.phase",  int'(bus.phase),      0);
        chk("mid.done",   int'(bus.done),       0);
        chk("mid.err",    int'(bus.err),        0);
        chk("mid.code",   int'(bus.err_code),   0);
        chk("mid.cnt",    int'(bus.sample_cnt), 0);
        chk("mid.inv_ok", int'(bus.inv_ok),     1);
        golden_range(0, 200);
        chk("mid.rerun_done", int'(bus.phase),      3);
        chk("mid.rerun_cnt",  int'(bus.sample_cnt), 201);

        // Random runs: legal stream with bubbles, corruptions, repeats and width edges
        for (int run = 0; run < 16; run++) begin
            do_reset("rnd_reset");
            for (int i = 0; i < 260; i++) begin
                int nx, ny, r;
                if (m_phase == 0 || m_phase == 4) begin
                    nx = (m_phase == 0) ? 0 : int'($urandom_range(0, 250));
                    ny = (m_phase == 0) ? YI : nx;
                end else begin
                    nx = (m_px < LIMIT) ? m_px + 1 : m_px;
                    ny = (m_px < LIMIT && m_px + 1 > KNEE) ? m_py + 1 : m_py;
                end
                r = int'($urandom_range(0, 299));
                if (r < 12) begin
                    step(1'b0, int'($urandom_range(0, XMAX)), int'($urandom_range(0, XMAX)), "rnd_idle");
                end else begin
                    if (r < 14)       nx = int'($urandom_range(0, XMAX));
                    else if (r < 16)  ny = ny + ((r & 1) ? 1 : -1);
                    else if (r < 17)  nx = XMAX;
                    else if (r < 18)  ny = XMAX;
                    else if (r < 20 && m_phase != 0) begin
                        nx = m_px;
                        ny = m_py;
                    end
                    step(1'b1, nx & XMAX, ny & XMAX, "rnd");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_fib_step_monitor
`default_nettype wire

// File: doc/fib_step_monitor.md
Name: fib_step_monitor

Overview:
- Downstream checker for the (x, y) counter stage in the simple-arithmetic benchmarks.
- Samples each (x, y) pair the counter produces and replays the counter's step rule against the previously accepted pair.
- Tracks the run phase (flat, ramp, done) and flags the first illegal step or invariant failure.
- Its outputs feed property-mining traces and formal assertion hooks.

Parameters:
- W, 11, width of x and y.
- X_KNEE, 100, last x value for which y is held constant.
- X_LIMIT, 200, x saturation value.
- Y_INIT, 100, required y on the first sample after reset.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on the clk rising edge.
- in_valid  in  1  the current x/y pair is a new upstream sample.
- x  in  W  upstream x.
- y  in  W  upstream y.
- phase  out  3  current FSM state (encoding from package).
- done  out  1  high while in DONE.
- err  out  1  sticky error flag.
- err_code  out  3  code of the first error; 0 = none.
- sample_cnt  out  CNT_W  accepted samples, saturating.
- inv_ok  out  1  registered result of (x < X_LIMIT) || (y == X_LIMIT) for the last sample.

Behaviour:
- Reset (rst_n = 0 at a clk edge) is allowed at any time, including mid-run. All state returns to reset values on the next edge:
  - phase = IDLE, done = 0, err = 0, err_code = 0, sample_cnt = 0, inv_ok = 1.
  - The stored previous pair (px, py) is cleared to 0.
- Samples are only evaluated when in_valid = 1. With in_valid = 0 all registers hold.
- Every output is registered. The verdict for a sample is visible one cycle after the edge that sampled it.
- Expected next pair, computed from (px, py) using W+1-bit arithmetic so nothing wraps:
  - px < X_LIMIT and px+1 <= X_KNEE: expect (px+1, py).
  - px < X_LIMIT and px+1 > X_KNEE: expect (px+1, py+1).
  - Otherwise: expect (px, py).
- Error checks, in priority order; only the first error is recorded:
  - 1 BAD_INIT: the first sample in IDLE is not (0, Y_INIT).
  - 4 INV_FAIL: the invariant (x < X_LIMIT) || (y == X_LIMIT) is false for the sample.
  - 2 BAD_X: x differs from the expected x.
  - 3 BAD_Y: y differs from the expected y.
- On any error: err latches to 1, err_code latches, and phase moves to FAIL. FAIL is absorbing until reset. Further samples update inv_ok only.
- FSM transitions:
  - IDLE → FLAT on a valid, correct first sample.
  - FLAT → RAMP when an accepted x > X_KNEE.
  - RAMP → DONE when an accepted x == X_LIMIT.
  - DONE holds while samples equal (X_LIMIT, y_prev). done = 1 in DONE.
  - Any state → FAIL on error.
- On each accepted sample: (px, py) ← (x, y), and sample_cnt increments. sample_cnt saturates at 2^CNT_W-1 with no wrap.
- Width edges:
  - A sample with x = 2^W-1 is compared without overflow; an expected value of 2^W never matches.
  - If y = 2^W-1 at the ramp, the expected y+1 is 2^W, so the sample fails with BAD_Y.
- A sample that is both bad-init and invariant-failing reports code 1.

Optional Feature:
- Macro FIB_MON_STALL_EN.
- Defined: in FLAT or RAMP, a sample exactly equal to (px, py) is accepted as an upstream stall. No error, no state change, and sample_cnt still increments.
- Undefined: a repeated pair before DONE reports BAD_X (code 2).

Decomposition:
- Package fib_mon_pkg holds:
  - Phase enum: IDLE=0, FLAT=1, RAMP=2, DONE=3, FAIL=4.
  - err_code enum with values 0-4.
  - Default constants X_KNEE, X_LIMIT, Y_INIT.
- One natural sub-module: fib_step_model. It is purely combinational: (px, py) → (exp_x, exp_y), and carries the W+1-bit arithmetic.
- The monitor instantiates fib_step_model and holds the FSM, registers and counters.

Test Plan:
- Golden run: drive the exact counter sequence (0,100) → (200,200), then 5 hold cycles. Required: phase FLAT at x=1..100, RAMP at x=101, DONE at x=200 with done=1, err=0, sample_cnt=206.
- Bad init: first sample (0,99). Required: err=1, err_code=1, phase=FAIL; later legal samples do not change err_code.
- Bad y on the ramp: after a legal run to (150,150), send (151,150). Required: err_code=3, FAIL.
- Invariant failure: after (199,199), send (200,199). Required: inv_ok=0, err_code=4 (beats BAD_Y).
- Stall: send a repeated (50,100), once with FIB_MON_STALL_EN defined and once without. Required: no error and sample_cnt+1 when defined; err_code=2 when undefined.
- Reset mid-run: rst_n=0 for 1 cycle at (120,120), then restart from (0,100). Required: all outputs at reset values one cycle after the edge, and a clean golden run afterwards.
